axi_pkt_gen: RTL

- Settings-bus-programmed AXI4-Stream packet source that emits 64-bit routed packets.
- Each packet is a header word carrying a 16-bit DST field (the field the crossbar routes on), followed by N patterned payload words.
- Sits upstream of a crossbar input port. Used as a traffic generator for crossbar bring-up and loopback tests.

---
 rtl/axi_pkt_gen_pkg.sv | 40 ++++
 rtl/setting_reg.sv | 35 +++
 rtl/axi_pkt_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkt_gen_pkg.sv
// Shared definitions for the AXI4-Stream packet generator: settings register offsets,
// FSM state encoding, header field positions and a header packing helper.
package axi_pkt_gen_pkg;

  // Register offsets relative to SR_BASE
  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_ROUTE = 1;
  localparam int unsigned REG_LEN   = 2;
  localparam int unsigned REG_GAP   = 3;
  localparam int unsigned REG_NUM   = 4;

  localparam int unsigned SEQ_BITS = 12;

  // Header word layout: {4'h0, seq, len_bytes, src, dst}
  localparam int unsigned HDR_DST_LSB = 0;
  localparam int unsigned HDR_SRC_LSB = 16;
  localparam int unsigned HDR_LEN_LSB = 32;
  localparam int unsigned HDR_SEQ_LSB = 48;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StGap
  } state_e;

  // route is {src, dst} as held in the ROUTE register
  function automatic logic [63:0] pack_header(logic [SEQ_BITS-1:0] seq,
                                              logic [15:0]         len_bytes,
                                              logic [31:0]         route);
    logic [63:0] w;
    w = '0;
    w[HDR_SEQ_LSB +: SEQ_BITS] = seq;
    w[HDR_LEN_LSB +: 16]       = len_bytes;
    w[HDR_SRC_LSB +: 16]       = route[31:16];
    w[HDR_DST_LSB +: 16]       = route[15:0];
    return w;
  endfunction

endpackage

// File: rtl/setting_reg.sv
// Settings-bus register: captures in_i[Width-1:0] when strobe_i is high and addr_i
// equals MyAddr.
// Ports: clk_i, rst_ni (async active-low), strobe_i, addr_i, in_i (32-bit data),
//        out_o (registered value).
module setting_reg #(
  parameter int unsigned      MyAddr  = 0,
  parameter int unsigned      AWidth  = 16,
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] AtReset = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              strobe_i,
  input  logic [AWidth-1:0] addr_i,
  input  logic [31:0]       in_i,
  output logic [Width-1:0]  out_o
);

  logic [Width-1:0] out_q;
  logic             unused_in;

  // Narrow registers ignore the upper data bits
  assign unused_in = ^in_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= AtReset;
    end else if (strobe_i && (addr_i == AWidth'(MyAddr))) begin
      out_q <= in_i[Width-1:0];
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/axi_pkt_gen.sv
// Settings-bus programmed AXI4-Stream packet source. Each packet is one header word
// carrying the routing DST field, followed by LEN patterned payload words.
// Ports:
//   clk, reset (async active-low), clear (sync soft clear)
//   set_stb/set_addr/set_data : settings bus (CTRL, ROUTE, LEN, GAP, NUM at SR_BASE+0..4)
//   o_tdata/o_tvalid/o_tlast/o_tready : 64-bit AXI4-Stream master
//   busy : FSM not idle; pkt_count : packets completed since reset/clear (wraps)
module axi_pkt_gen
  import axi_pkt_gen_pkg::*;
#(
  parameter int unsigned SR_BASE   = 0,
  parameter int unsigned SR_AWIDTH = 16,
  parameter int unsigned LEN_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  output logic [63:0]          o_tdata,
  output logic                 o_tvalid,
  output logic                 o_tlast,
  input  logic                 o_tready,
  output logic                 busy,
  output logic [31:0]          pkt_count
);

  // ---------------------------------------------------------------------------
  // Settings registers
  // ---------------------------------------------------------------------------
  logic [1:0]          ctrl_q;
  logic [31:0]         route_q;
  logic [LEN_BITS-1:0] len_q;
  logic [15:0]         gap_q;
  logic [15:0]         num_q;

  setting_reg #(.MyAddr(SR_BASE + REG_CTRL), .AWidth(SR_AWIDTH), .Width(2)) u_reg_ctrl (
    .clk_i(clk), .rst_ni(reset), .strobe_i(set_stb), .addr_i(set_addr), .in_i(set_data),
    .out_o(ctrl_q)
  );

  setting_reg #(.MyAddr(SR_BASE + REG_ROUTE), .AWidth(SR_AWIDTH), .Width(32)) u_reg_route (
    .clk_i(clk), .rst_ni(reset), .strobe_i(set_stb), .addr_i(set_addr), .in_i(set_data),
    .out_o(route_q)
  );

  setting_reg #(.MyAddr(SR_BASE + REG_LEN), .AWidth(SR_AWIDTH), .Width(LEN_BITS)) u_reg_len (
    .clk_i(clk), .rst_ni(reset), .strobe_i(set_stb), .addr_i(set_addr), .in_i(set_data),
    .out_o(len_q)
  );

  setting_reg #(.MyAddr(SR_BASE + REG_GAP), .AWidth(SR_AWIDTH), .Width(16)) u_reg_gap (
    .clk_i(clk), .rst_ni(reset), .strobe_i(set_stb), .addr_i(set_addr), .in_i(set_data),
    .out_o(gap_q)
  );

  setting_reg #(.MyAddr(SR_BASE + REG_NUM), .AWidth(SR_AWIDTH), .Width(16)) u_reg_num (
    .clk_i(clk), .rst_ni(reset), .strobe_i(set_stb), .addr_i(set_addr), .in_i(set_data),
    .out_o(num_q)
  );

  // Register values as they will be after this edge. Shadow loads and go/stop decisions
  // use these so a write coinciding with end-of-packet is seen by the next header.
  logic                wr_ctrl, wr_route, wr_len, wr_gap, wr_num;
  logic                go_nxt, mode_nxt;
  logic [31:0]         route_nxt;
  logic [LEN_BITS-1:0] len_nxt;
  logic [15:0]         gap_nxt, num_nxt;

  assign wr_ctrl  = set_stb && (set_addr == SR_AWIDTH'(SR_BASE + REG_CTRL));
  assign wr_route = set_stb && (set_addr == SR_AWIDTH'(SR_BASE + REG_ROUTE));
  assign wr_len   = set_stb && (set_addr == SR_AWIDTH'(SR_BASE + REG_LEN));
  assign wr_gap   = set_stb && (set_addr == SR_AWIDTH'(SR_BASE + REG_GAP));
  assign wr_num   = set_stb && (set_addr == SR_AWIDTH'(SR_BASE + REG_NUM));

  assign go_nxt    = wr_ctrl  ? set_data[0]              : ctrl_q[0];
  assign mode_nxt  = wr_ctrl  ? set_data[1]              : ctrl_q[1];
  assign route_nxt = wr_route ? set_data                 : route_q;
  assign len_nxt   = wr_len   ? set_data[LEN_BITS-1:0]   : len_q;
  assign gap_nxt   = wr_gap   ? set_data[15:0]           : gap_q;
  assign num_nxt   = wr_num   ? set_data[15:0]           : num_q;

  // ---------------------------------------------------------------------------
  // Per-packet shadow copies, loaded on every entry to the header state
  // ---------------------------------------------------------------------------
  logic                hdr_enter;
  logic [31:0]         route_s_q;
  logic [LEN_BITS-1:0] len_s_q;
  logic [15:0]         gap_s_q;
  logic                mode_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_s_q <= '0;
      len_s_q   <= '0;
      gap_s_q   <= '0;
      mode_s_q  <= 1'b0;
    end else if (hdr_enter) begin
      route_s_q <= route_nxt;
      len_s_q   <= len_nxt;
      gap_s_q   <= gap_nxt;
      mode_s_q  <= mode_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and counters
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [SEQ_BITS-1:0] seq_q, seq_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  logic [15:0]         rem_q, rem_d;
  logic                unlim_q, unlim_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic                hs, eop;

  assign hs = o_tvalid & o_tready;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    pkt_cnt_d = pkt_cnt_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    unlim_d   = unlim_q;
    gap_cnt_d = gap_cnt_q;
    hdr_enter = 1'b0;
    eop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_ctrl && set_data[0]) begin
          state_d   = StHeader;
          rem_d     = num_nxt;
          unlim_d   = (num_nxt == 16'd0);
          hdr_enter = 1'b1;
        end
      end
      StHeader: begin
        if (hs) begin
          if (len_s_q == '0) begin
            eop = 1'b1;
          end else begin
            state_d = StPayload;
            idx_d   = LEN_BITS'(1);
          end
        end
      end
      StPayload: begin
        if (hs) begin
          if (idx_q == len_s_q) begin
            eop = 1'b1;
          end else begin
            idx_d = idx_q + LEN_BITS'(1);
          end
        end
      end
      StGap: begin
        if (!go_nxt) begin
          state_d = StIdle;
        end else if (gap_cnt_q == 16'd1) begin
          state_d   = StHeader;
          hdr_enter = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (eop) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      seq_d     = seq_q + SEQ_BITS'(1);
      if (!unlim_q) begin
        rem_d = rem_q - 16'd1;
      end
      if (!go_nxt || (!unlim_q && (rem_q == 16'd1))) begin
        state_d = StIdle;
      end else if (gap_s_q == 16'd0) begin
        state_d   = StHeader;
        hdr_enter = 1'b1;
      end else begin
        state_d   = StGap;
        gap_cnt_d = gap_s_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      unlim_q   <= 1'b0;
      gap_cnt_q <= '0;
    end else if (clear) begin
      // Registers are kept; any packet in flight is dropped
      state_q   <= StIdle;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      unlim_q   <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      pkt_cnt_q <= pkt_cnt_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      unlim_q   <= unlim_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so o_tready never reaches o_tvalid
  // ---------------------------------------------------------------------------
  logic [15:0] len_bytes;

  assign len_bytes = (16'(len_s_q) + 16'd1) << 3;

  always_comb begin
    o_tdata  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    unique case (state_q)
      StHeader: begin
        o_tvalid = 1'b1;
        o_tlast  = (len_s_q == '0);
        o_tdata  = pack_header(seq_q, len_bytes, route_s_q);
      end
      StPayload: begin
        o_tvalid = 1'b1;
        o_tlast  = (idx_q == len_s_q);
        o_tdata  = mode_s_q ? {route_s_q, route_s_q} : {20'h0, seq_q, 32'(idx_q)};
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign pkt_count = pkt_cnt_q;

endmodule
